alu_multicycle: RTL

- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Executes one operation per start/done handshake.
- Logic, arithmetic, LUI and branch compares complete in 1 cycle. SRL/SLL iterate 1 bit per cycle, so a slow, compact shifter can sit behind the decoder in the multi-cycle core variant.
- Result, branch-taken flag and illegal-op flag are registered and held until the next operation completes.

---
 rtl/alu_multicycle.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: execution-side ALU that consumes the 4-bit operation code
// from the ALU control decoder. One operation per start/done handshake.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   start_i         request, sampled only while idle
//   ALU_Operation_i 4-bit operation code
//   A_i, B_i        operands (B_i[SHAMT_WIDTH-1:0] is the shift amount)
//   busy_o          high whenever an operation is in flight (state != IDLE)
//   done_o          one-cycle completion pulse
//   result_o        registered result, held until the next completion
//   branch_taken_o  registered branch decision
//   illegal_o       registered unsupported-opcode flag
//
// Build option: define ALU_BARREL_SHIFT_EN to replace the iterative
// 1-bit/cycle shifter with a combinational barrel shifter. Results and flags
// are identical in both builds; only shift latency differs.
//
// state | meaning
// IDLE  | waiting for start_i; non-shift ops complete from here
// SHIFT | iterative shift in progress, one bit per cycle (default build only)
// DONE  | done_o pulse; outputs already hold the new values

module alu_multicycle #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  branch_taken_o,
    output logic                  illegal_o
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1010;
    localparam logic [3:0] OP_BLT = 4'b1011;
    localparam logic [3:0] OP_BGE = 4'b1100;

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t state_q, state_d;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  diff;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic                   alu_taken;
    logic                   alu_illegal;

    assign shamt = B_i[SHAMT_WIDTH-1:0];
    assign diff  = A_i - B_i;

`ifndef ALU_BARREL_SHIFT_EN
    logic                   start_shift;
    logic [DATA_WIDTH-1:0]  work_q;
    logic [DATA_WIDTH-1:0]  work_next;
    logic [SHAMT_WIDTH-1:0] count_q;
    logic                   shift_left_q;
    logic                   count_tc;

    assign start_shift = ((ALU_Operation_i == OP_SRL) || (ALU_Operation_i == OP_SLL))
                         && (shamt != '0);
    assign work_next   = shift_left_q ? (work_q << 1) : (work_q >> 1);
    assign count_tc    = (count_q == SHAMT_WIDTH'(1));
`endif

    // Single-cycle datapath. In the iterative build this path only ever sees
    // shifts with shamt == 0, which return A unchanged.
    always_comb begin
        alu_res     = '0;
        alu_taken   = 1'b0;
        alu_illegal = 1'b0;
        case (ALU_Operation_i)
            OP_ADD: alu_res = A_i + B_i;
            OP_SUB: alu_res = diff;
            OP_AND: alu_res = A_i & B_i;
            OP_OR:  alu_res = A_i | B_i;
            OP_XOR: alu_res = A_i ^ B_i;
            OP_LUI: alu_res = B_i;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SRL: alu_res = A_i >> shamt;
            OP_SLL: alu_res = A_i << shamt;
`else
            OP_SRL: alu_res = A_i;
            OP_SLL: alu_res = A_i;
`endif
            OP_BEQ: begin
                alu_res   = diff;
                alu_taken = (A_i == B_i);
            end
            OP_BNE: begin
                alu_res   = diff;
                alu_taken = (A_i != B_i);
            end
            OP_BLT: begin
                alu_res   = diff;
                alu_taken = ($signed(A_i) < $signed(B_i));
            end
            OP_BGE: begin
                alu_res   = diff;
                alu_taken = ($signed(A_i) >= $signed(B_i));
            end
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start_i) begin
`ifdef ALU_BARREL_SHIFT_EN
                    state_d = DONE;
`else
                    state_d = start_shift ? SHIFT : DONE;
`endif
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            SHIFT: begin
                if (count_tc) begin
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_o       <= '0;
            branch_taken_o <= 1'b0;
            illegal_o      <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            work_q         <= '0;
            count_q        <= '0;
            shift_left_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (start_shift) begin
                            work_q       <= A_i;
                            count_q      <= shamt;
                            shift_left_q <= (ALU_Operation_i == OP_SLL);
                        end else
`endif
                        begin
                            result_o       <= alu_res;
                            branch_taken_o <= alu_taken;
                            illegal_o      <= alu_illegal;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    work_q  <= work_next;
                    count_q <= count_q - SHAMT_WIDTH'(1);
                    if (count_tc) begin
                        result_o       <= work_next;
                        branch_taken_o <= 1'b0;
                        illegal_o      <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
